// File: rtl/enemy_pkg.sv
// enemy_pkg: playfield geometry, slot state type and slot row/column helpers
package enemy_pkg;
  localparam int ROW_X [3] = '{40, 60, 90};
  localparam int COL_PITCH = 170;
  localparam int Y0 = 50;
  localparam int ROW_PITCH = 130;
  typedef enum logic {IDLE, ACTIVE} slot_state_e;
  function automatic int slot_row(input int k);
    return k / 3;
  endfunction
  function automatic int slot_col(input int k);
    return k % 3;
  endfunction
endpackage

// File: rtl/enemy_grid_ctrl_if.sv
// enemy_grid_ctrl_if: game-side and render-side signals of the enemy grid controller
interface enemy_grid_ctrl_if #(parameter int SLOTS = 9, parameter int ADDR_W = 15);
  logic              tick;
  logic              spawn_valid;
  logic [3:0]        spawn_slot;
  logic              spawn_ready;
  logic              hit_valid;
  logic [3:0]        hit_slot;
  logic              hit_ack;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [ADDR_W-1:0] sprite_addr;
  logic              sprite_en;
  logic [SLOTS-1:0]  active;
  logic              damage;
  logic [3:0]        damage_cnt;
  modport master (output tick, spawn_valid, spawn_slot, hit_valid, hit_slot, h_cnt, v_cnt,
                  input spawn_ready, hit_ack, sprite_addr, sprite_en, active, damage, damage_cnt);
  modport slave  (input tick, spawn_valid, spawn_slot, hit_valid, hit_slot, h_cnt, v_cnt,
                  output spawn_ready, hit_ack, sprite_addr, sprite_en, active, damage, damage_cnt);
endinterface

// File: rtl/enemy_slot.sv
// enemy_slot: one enemy's IDLE/ACTIVE state and life countdown
module enemy_slot import enemy_pkg::*; #(
  parameter int LIFE_TICKS = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic spawn_i,
  input  logic hit_i,
  output logic active_o,
  output logic hit_o,
  output logic escape_o
);
  localparam int CW = $clog2(LIFE_TICKS + 1);
  slot_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // a hit on the final tick takes precedence over the escape
  always_comb begin
    active_o = state_q == ACTIVE;
    hit_o    = active_o && hit_i;
    escape_o = active_o && tick_i && cnt_q == CW'(1) && !hit_i;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (spawn_i && !active_o) begin
      state_d = ACTIVE;
      cnt_d   = CW'(LIFE_TICKS);
    end else if (hit_o || escape_o) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (active_o && tick_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/enemy_grid_ctrl.sv
// enemy_grid_ctrl: enemy slots on the 3x3 key grid with sprite hit-test and damage count
module enemy_grid_ctrl import enemy_pkg::*; #(
  parameter int SLOTS      = 9,
  parameter int SPR_W      = 160,
  parameter int SPR_H      = 120,
  parameter int LIFE_TICKS = 48,
  parameter int ADDR_W     = 15
) (
  input logic clk,
  input logic rst,
  enemy_grid_ctrl_if.slave bus
);
  logic [SLOTS-1:0]  sel, active, hit, esc, in_spr;
  logic [ADDR_W-1:0] addr [SLOTS];
  logic [11:0]       hx, vy;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              en_d, en_q, hit_ack_q, damage_q;
  logic [3:0]        dcnt_d, dcnt_q;
  assign hx = {2'b0, bus.h_cnt};
  assign vy = {2'b0, bus.v_cnt};
  genvar k;
  for (k = 0; k < SLOTS; k++) begin : g_slot
    localparam int XK = ROW_X[slot_row(k)] + slot_col(k) * COL_PITCH;
    localparam int YK = Y0 + slot_row(k) * ROW_PITCH;
    assign sel[k] = bus.spawn_slot == 4'(k);
    enemy_slot #(.LIFE_TICKS(LIFE_TICKS)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (bus.tick),
      .spawn_i  (bus.spawn_valid && sel[k]),
      .hit_i    (bus.hit_valid && bus.hit_slot == 4'(k)),
      .active_o (active[k]),
      .hit_o    (hit[k]),
      .escape_o (esc[k])
    );
    assign in_spr[k] = active[k] && hx > 12'(XK) && hx < 12'(XK + SPR_W)
                                 && vy > 12'(YK) && vy < 12'(YK + SPR_H);
    assign addr[k] = ADDR_W'(hx - 12'(XK)) + ADDR_W'(vy - 12'(YK)) * ADDR_W'(SPR_W);
  end
  assign bus.spawn_ready = |(sel & ~active);
  assign bus.active      = active;
  // scanning from the top index down lets the lowest overlapping slot win
  always_comb begin
    addr_d = '0;
    en_d   = 1'b0;
    dcnt_d = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      addr_d = in_spr[i] ? addr[i] : addr_d;
      en_d   = en_d || in_spr[i];
    end
    for (int i = 0; i < SLOTS; i++) dcnt_d = dcnt_d + 4'(esc[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      en_q      <= 1'b0;
      hit_ack_q <= 1'b0;
      damage_q  <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      addr_q    <= addr_d;
      en_q      <= en_d;
      hit_ack_q <= |hit;
      damage_q  <= |esc;
      dcnt_q    <= dcnt_d;
    end
  end
  assign bus.sprite_addr = addr_q;
  assign bus.sprite_en   = en_q;
  assign bus.hit_ack     = hit_ack_q;
  assign bus.damage      = damage_q;
  assign bus.damage_cnt  = dcnt_q;
endmodule

// File: tb/tb_enemy_grid_ctrl.sv
// tb_enemy_grid_ctrl: directed checks of spawn, render, hit, expiry and reset behaviour
module tb_enemy_grid_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  enemy_grid_ctrl_if #(.SLOTS(9), .ADDR_W(15)) bus ();
  enemy_grid_ctrl #(.SLOTS(9), .SPR_W(160), .SPR_H(120), .LIFE_TICKS(3), .ADDR_W(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic spawn(input int s);
    bus.spawn_valid = 1'b1;
    bus.spawn_slot  = 4'(s);
    step();
    bus.spawn_valid = 1'b0;
  endtask
  task automatic tick_once();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask
  initial begin
    bus.tick = 0; bus.spawn_valid = 0; bus.spawn_slot = 0;
    bus.hit_valid = 0; bus.hit_slot = 0; bus.h_cnt = 0; bus.v_cnt = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_en", 32'(bus.sprite_en), 0);
    chk("rst_addr", 32'(bus.sprite_addr), 0);
    chk("rst_hit_ack", 32'(bus.hit_ack), 0);
    chk("rst_damage", 32'(bus.damage), 0);
    chk("rst_dcnt", 32'(bus.damage_cnt), 0);
    // render slot 4 (x0=230, y0=180)
    bus.h_cnt = 231; bus.v_cnt = 181;
    bus.spawn_valid = 1'b1; bus.spawn_slot = 4;
    #1 chk("ready_idle", 32'(bus.spawn_ready), 1);
    step();
    bus.spawn_valid = 1'b0;
    chk("active_s4", 32'(bus.active), 32'h010);
    chk("en_accept_cycle", 32'(bus.sprite_en), 0);
    step();
    chk("en_inside", 32'(bus.sprite_en), 1);
    chk("addr_inside", 32'(bus.sprite_addr), 161);
    bus.h_cnt = 230;
    step();
    chk("en_left_edge", 32'(bus.sprite_en), 0);
    chk("addr_left_edge", 32'(bus.sprite_addr), 0);
    bus.h_cnt = 389; bus.v_cnt = 299;
    step();
    chk("en_far_corner", 32'(bus.sprite_en), 1);
    chk("addr_far_corner", 32'(bus.sprite_addr), 19199);
    bus.h_cnt = 390;
    step();
    chk("en_right_edge", 32'(bus.sprite_en), 0);
    // hits on idle / out-of-range slots
    bus.hit_valid = 1'b1; bus.hit_slot = 0;
    step();
    chk("hit_idle", 32'(bus.hit_ack), 0);
    bus.hit_slot = 9;
    step();
    bus.hit_valid = 1'b0;
    chk("hit_oor", 32'(bus.hit_ack), 0);
    // rejected spawns must not reload slot 4's counter
    tick_once();
    bus.spawn_valid = 1'b1; bus.spawn_slot = 4;
    #1 chk("ready_busy", 32'(bus.spawn_ready), 0);
    step();
    bus.spawn_slot = 9;
    #1 chk("ready_oor", 32'(bus.spawn_ready), 0);
    step();
    bus.spawn_valid = 1'b0;
    chk("oor_no_change", 32'(bus.active), 32'h010);
    tick_once();
    chk("s4_no_dmg_yet", 32'(bus.damage), 0);
    tick_once();
    chk("s4_dmg", 32'(bus.damage), 1);
    chk("s4_dcnt", 32'(bus.damage_cnt), 1);
    chk("s4_gone", 32'(bus.active), 0);
    step();
    chk("dmg_pulse", 32'(bus.damage), 0);
    chk("dcnt_zero", 32'(bus.damage_cnt), 0);
    // slot 0 expires on its third tick; a tick in the accept cycle is ignored
    bus.tick = 1'b1;
    spawn(0);
    bus.tick = 1'b0;
    tick_once(); tick_once();
    chk("s0_pre_expiry", 32'(bus.damage), 0);
    tick_once();
    chk("s0_dmg", 32'(bus.damage), 1);
    chk("s0_dcnt", 32'(bus.damage_cnt), 1);
    chk("s0_inactive", 32'(bus.active[0]), 0);
    // hit on the final tick wins
    spawn(0);
    tick_once(); tick_once();
    bus.tick = 1'b1; bus.hit_valid = 1'b1; bus.hit_slot = 0;
    step();
    bus.tick = 1'b0; bus.hit_valid = 1'b0;
    chk("hitwin_ack", 32'(bus.hit_ack), 1);
    chk("hitwin_dmg", 32'(bus.damage), 0);
    chk("hitwin_active", 32'(bus.active), 0);
    step();
    chk("hit_ack_pulse", 32'(bus.hit_ack), 0);
    // spawn and hit to the same idle slot: spawn wins
    bus.hit_valid = 1'b1; bus.hit_slot = 1;
    spawn(1);
    bus.hit_valid = 1'b0;
    chk("spawnhit_ack", 32'(bus.hit_ack), 0);
    chk("spawnhit_active", 32'(bus.active), 32'h002);
    bus.hit_valid = 1'b1;
    step();
    bus.hit_valid = 1'b0;
    chk("hit_s1_ack", 32'(bus.hit_ack), 1);
    chk("hit_s1_active", 32'(bus.active), 0);
    // aligned expiry of slots 2, 5, 8
    spawn(2); spawn(5); spawn(8);
    chk("three_active", 32'(bus.active), 32'h124);
    tick_once(); tick_once();
    chk("three_pre", 32'(bus.damage), 0);
    tick_once();
    chk("three_dmg", 32'(bus.damage), 1);
    chk("three_dcnt", 32'(bus.damage_cnt), 3);
    chk("three_gone", 32'(bus.active), 0);
    // reset with four live enemies
    bus.h_cnt = 231; bus.v_cnt = 181;
    spawn(1); spawn(3); spawn(4); spawn(6);
    step();
    chk("four_active", 32'(bus.active), 32'h05A);
    chk("four_en", 32'(bus.sprite_en), 1);
    rst = 1'b1; bus.tick = 1'b1;
    step();
    rst = 1'b0; bus.tick = 1'b0;
    chk("mid_rst_active", 32'(bus.active), 0);
    chk("mid_rst_dmg", 32'(bus.damage), 0);
    chk("mid_rst_en", 32'(bus.sprite_en), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enemy_grid_ctrl.md
# enemy_grid_ctrl

Parametrised enemy-slot controller for the whack-a-mole playfield, the successor to the single-sprite enemy renderer. It tracks up to `SLOTS` independent enemies on the 3-column key grid (Q W E / A S D / Z X C), and for each one manages spawning, a lifetime countdown, player hits and escape damage. It also generates the registered sprite-ROM address and enable for the current VGA pixel. It sits between the game FSM/keyboard decoder and the sprite block RAM plus pixel mux.

## Interface
Parameters:
- `SLOTS`, 9: number of enemy slots (1..9); slot k lives at row k/3, column k%3.
- `SPR_W`, 160: sprite width in pixels.
- `SPR_H`, 120: sprite height in pixels.
- `LIFE_TICKS`, 48: ticks an enemy stays up before escaping (≥1).
- `ADDR_W`, 15: sprite ROM address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input, 1: system clock.
- `rst` input, 1: synchronous active-high reset.
- `tick` input, 1: game-time strobe, one `clk` cycle wide.
- `spawn_valid` input, 1: request to spawn an enemy.
- `spawn_slot` input, 4: target slot index.
- `spawn_ready` output, 1: combinational; high when `spawn_slot` < `SLOTS` and that slot is IDLE.
- `hit_valid` input, 1: player pressed a key.
- `hit_slot` input, 4: slot index of the key pressed.
- `hit_ack` output, 1: one-cycle pulse, the hit removed a live enemy.
- `h_cnt`, `v_cnt` input, 10 each: VGA counters.
- `sprite_addr` output, ADDR_W: registered ROM address.
- `sprite_en` output, 1: registered; the current pixel is inside a live enemy.
- `active` output, SLOTS: per-slot ACTIVE flags.
- `damage` output, 1: one-cycle pulse when at least one enemy escapes.
- `damage_cnt` output, 4: number of enemies escaping this cycle. Valid with `damage`, 0 otherwise.

## Operation
- Per-slot FSM:
  - IDLE → ACTIVE on `spawn_valid && spawn_ready`; life counter loads `LIFE_TICKS`.
  - ACTIVE: counter decrements on `tick`.
  - ACTIVE → IDLE on a hit for this slot; pulses `hit_ack`.
  - ACTIVE → IDLE when counter is 1 and `tick` is high; counts toward `damage_cnt`.
- Hit and expiry on the same slot in the same cycle: the hit wins. Result is `hit_ack`, no damage.
- Hit on an IDLE slot or with `hit_slot` ≥ `SLOTS`: ignored, no `hit_ack`.
- Spawn and hit to the same IDLE slot in the same cycle: the spawn is accepted and the hit is ignored.
- Out-of-range spawn: `spawn_ready`=0, no state change.
- Geometry constants:
  - Origin x0 = ROW_X[row] + col·COL_PITCH, y0 = Y0 + row·ROW_PITCH.
  - Defaults: ROW_X={40,60,90}, COL_PITCH=170, Y0=50, ROW_PITCH=130.
- A pixel is inside slot k when x0 < h_cnt < x0+SPR_W and y0 < v_cnt < y0+SPR_H (strict) and slot k is ACTIVE.
- Address = (h_cnt−x0) + (v_cnt−y0)·SPR_W.
  - Max 159+119·160 = 19199, so no modulo.
  - Computed at ADDR_W bits without truncation at the defaults.
- Overlap (non-default geometry): the lowest slot index wins. If no slot hits, the address is 0 and `sprite_en`=0.

## Timing
- Reset: all slots IDLE, counters 0, `active`=0, `sprite_addr`=0, `sprite_en`=0, `hit_ack`=0, `damage`=0, `damage_cnt`=0.
- `rst` asserted mid-life drops all enemies the next edge, with no damage.
- Render path latency is 1 cycle: `sprite_addr`/`sprite_en` reflect the `h_cnt`/`v_cnt` of the previous cycle. ROM read adds its own cycle downstream.
- Slot state updates at the edge after the accepting cycle; `active` is visible one cycle after the spawn.
- An enemy spawned in cycle t is rendered for pixels sampled from t+1.
- `hit_ack`, `damage`, `damage_cnt` are registered and assert the cycle after the causing event.
- With `LIFE_TICKS`=N, expiry occurs on the N-th `tick` after acceptance. A `tick` in the acceptance cycle does not count.

## Structure
- Package `enemy_pkg` holds:
  - the ROW_X/COL_PITCH/Y0/ROW_PITCH constants;
  - the slot state enum {IDLE, ACTIVE};
  - the helper functions slot_row/slot_col.
- One sub-module, `enemy_slot`, instantiated `SLOTS` times. It contains the FSM and life counter and exports active/hit/escape.
- The top level holds the hit-test/address mux and the damage popcount.

## Test plan
- Reset, spawn slot 4 (S), then h_cnt=231, v_cnt=181 → next cycle `sprite_en`=1, `sprite_addr`=161. At h_cnt=230, `sprite_en`=0.
- Spawn slot 0 with LIFE_TICKS=3 and apply 3 ticks → `damage`=1 and `damage_cnt`=1 one cycle after the 3rd tick; `active[0]`=0.
- Hit slot 0 in the same cycle as its final tick → `hit_ack`=1, `damage`=0.
- Spawn slots 2, 5, 8 together over 3 cycles with expiry aligned → single `damage` pulse with `damage_cnt`=3.
- Spawn to an ACTIVE slot, and spawn_slot=9 with SLOTS=9 → `spawn_ready`=0 and the counter is not reloaded. A hit on an IDLE slot gives no `hit_ack`.
- Assert `rst` with 4 live enemies → next cycle `active`=0, `damage`=0, `sprite_en`=0.
